// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder
// Data-bus responder for a single-cycle ARM core. Decodes the core's data port
// into a word RAM (A[31:16] == 0) and a block of memory-mapped I/O registers
// at 0xFFFF0000..0xFFFF000C.
//
// I/O map:
//   0xFFFF0000 OUTQ   : write pushes WD onto the output queue; reads 0
//   0xFFFF0004 STATUS : {24'b0, count[3:0], ovf, tmatch, full, empty}
//                       write WD[3]=1 clears ovf, WD[2]=1 clears tmatch
//   0xFFFF0008 TIMER  : free-running counter, write loads WD
//   0xFFFF000C TCMP   : compare value
//
// Build option: define DBUS_TIMER_EN to build the timer, TCMP and tmatch.
// Without it TIMER/TCMP read 0, ignore writes, and STATUS bit 2 reads 0.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (clears queue, flags, timer)
//   A         byte address (A[1:0] ignored)
//   WD        store data
//   WE        store strobe
//   RD        load data, combinational from A and registered state
//   out_data  head-of-queue word (0 after reset)
//   out_valid queue non-empty (registered)
//   out_ready consumer accepts head word when out_valid is high
// -----------------------------------------------------------------------------
module dbus_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic              ram_sel_s;
    logic              io_sel_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic              outq_wr_s;
    logic              status_wr_s;
    logic              timer_wr_s;
    logic              tcmp_wr_s;
    logic              unused_s;

    assign ram_sel_s   = (A[31:16] == 16'h0000);
    assign io_sel_s    = (A[31:4] == 28'hFFFF000);
    assign ram_idx_s   = A[ADDR_W+1:2];
    assign outq_wr_s   = WE && io_sel_s && (A[3:2] == 2'd0);
    assign status_wr_s = WE && io_sel_s && (A[3:2] == 2'd1);
    assign timer_wr_s  = WE && io_sel_s && (A[3:2] == 2'd2);
    assign tcmp_wr_s   = WE && io_sel_s && (A[3:2] == 2'd3);
    // Address bits above the RAM index alias inside the RAM region.
    assign unused_s    = ^{A[15:ADDR_W+2], A[1:0]};

    // ---------------- word RAM ----------------
    logic [31:0] ram_r [0:(1<<ADDR_W)-1];

    // RAM store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (WE && ram_sel_s) begin
            ram_r[ram_idx_s] <= WD;
        end
    end

    // ---------------- output queue ----------------
    logic [31:0]      fifo_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [3:0]       count_r;
    logic             valid_r;
    logic             ovf_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_ok_s;
    logic [3:0]       count_next_s;
    logic             ovf_next_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == 4'd0);
    assign pop_s   = valid_r && out_ready;

    // Push acceptance, next count and overflow flag. A pop in the same cycle
    // frees a slot, so a push into a full queue is still accepted then.
    always_comb begin
        push_ok_s    = outq_wr_s && (!full_s || pop_s);
        count_next_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + 4'd1;
            2'b01:   count_next_s = count_r - 4'd1;
            default: count_next_s = count_r;
        endcase
        if (outq_wr_s && !push_ok_s) begin
            ovf_next_s = 1'b1;
        end else if (status_wr_s && WD[3]) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Queue storage, pointers, count, valid and overflow state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= 32'd0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= 4'd0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_r[wr_ptr_r] <= WD;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != 4'd0);
            ovf_r   <= ovf_next_s;
        end
    end

    assign out_data  = fifo_r[rd_ptr_r];
    assign out_valid = valid_r;

    // ---------------- timer ----------------
    logic [31:0] timer_val_s;
    logic [31:0] tcmp_val_s;
    logic        tmatch_s;

`ifdef DBUS_TIMER_EN
    logic [31:0] timer_r;
    logic [31:0] tcmp_r;
    logic        tmatch_r;

    // Counter, compare register and sticky match flag; a match set in the
    // same cycle as a software clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r  <= 32'd0;
            tcmp_r   <= 32'hFFFF_FFFF;
            tmatch_r <= 1'b0;
        end else begin
            if (timer_wr_s) begin
                timer_r <= WD;
            end else begin
                timer_r <= timer_r + 32'd1;
            end
            if (tcmp_wr_s) begin
                tcmp_r <= WD;
            end
            tmatch_r <= (timer_r == tcmp_r) ||
                        (tmatch_r && !(status_wr_s && WD[2]));
        end
    end

    assign timer_val_s = timer_r;
    assign tcmp_val_s  = tcmp_r;
    assign tmatch_s    = tmatch_r;
`else
    logic unused_timer_s;

    assign unused_timer_s = timer_wr_s ^ tcmp_wr_s;
    assign timer_val_s    = 32'd0;
    assign tcmp_val_s     = 32'd0;
    assign tmatch_s       = 1'b0;
`endif

    // ---------------- load data mux ----------------
    // Zero-latency read path: RAM word, I/O register, or 0 when unmapped.
    always_comb begin
        RD = 32'd0;
        if (ram_sel_s) begin
            RD = ram_r[ram_idx_s];
        end else if (io_sel_s) begin
            case (A[3:2])
                2'd0:    RD = 32'd0;
                2'd1:    RD = {24'd0, count_r, ovf_r, tmatch_s, full_s, empty_s};
                2'd2:    RD = timer_val_s;
                2'd3:    RD = tcmp_val_s;
                default: RD = 32'd0;
            endcase
        end else begin
            RD = 32'd0;
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// -----------------------------------------------------------------------------
// tb_dbus_responder
// Directed bench for dbus_responder. A behavioural model (associative-array
// RAM, SV queue, plain integer timer) tracks the expected state; a negedge
// compare process checks out_valid, out_data and RD against it every cycle,
// and directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dbus_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
`ifdef DBUS_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    localparam logic [31:0] OUTQ   = 32'hFFFF_0000;
    localparam logic [31:0] STATUS = 32'hFFFF_0004;
    localparam logic [31:0] TIMER  = 32'hFFFF_0008;
    localparam logic [31:0] TCMP   = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    dbus_responder #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .WD        (WD),
        .WE        (WE),
        .RD        (RD),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [31:0] m_ram [int];
    logic [31:0] m_q [$];
    logic        m_ovf    = 1'b0;
    logic        m_tmatch = 1'b0;
    logic [31:0] m_timer  = 32'd0;
    logic [31:0] m_tcmp   = 32'hFFFF_FFFF;

    logic [31:0] ma, mwd;
    logic        mwe, mio, mpop, mhit, mclr;
    int          msize;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected RD for an address; known=0 when the RAM word was never written.
    function automatic logic [31:0] model_rd(input logic [31:0] a, output bit known);
        int n;
        n     = m_q.size();
        known = 1'b1;
        if (a[31:16] == 16'h0000) begin
            if (m_ram.exists(int'(a[AW+1:2]))) return m_ram[int'(a[AW+1:2])];
            known = 1'b0;
            return 32'd0;
        end
        if (a[31:4] != 28'hFFFF000) return 32'd0;
        case (a[3:2])
            2'd1: return {24'd0, 4'(n), m_ovf, m_tmatch, (n == DEPTH), (n == 0)};
            2'd2: return TIMER_ON ? m_timer : 32'd0;
            2'd3: return TIMER_ON ? m_tcmp : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model: apply one clock edge's worth of effects from pre-edge state.
    initial forever begin
        @(posedge clk);
        if (reset === 1'b1) begin
            ma = A; mwd = WD; mwe = WE;
            msize = m_q.size();
            mio   = (ma[31:4] == 28'hFFFF000);
            mpop  = (msize != 0) && out_ready;
            mhit  = TIMER_ON && (m_timer == m_tcmp);
            mclr  = mwe && mio && ma[3:2] == 2'd1 && mwd[2];
            if (mpop) m_q.delete(0);
            if (mwe && mio && ma[3:2] == 2'd0) begin
                if (msize < DEPTH || mpop) m_q.push_back(mwd);
                else m_ovf = 1'b1;
            end
            if (mwe && mio && ma[3:2] == 2'd1 && mwd[3]) m_ovf = 1'b0;
            if (TIMER_ON) begin
                m_timer  = (mwe && mio && ma[3:2] == 2'd2) ? mwd : m_timer + 32'd1;
                if (mwe && mio && ma[3:2] == 2'd3) m_tcmp = mwd;
                m_tmatch = mhit || (m_tmatch && !mclr);
            end
            if (mwe && ma[31:16] == 16'h0000) m_ram[int'(ma[AW+1:2])] = mwd;
        end
    end

    // Model: asynchronous reset clears everything except RAM.
    initial forever begin
        @(negedge reset);
        m_q.delete();
        m_ovf    = 1'b0;
        m_tmatch = 1'b0;
        m_timer  = 32'd0;
        m_tcmp   = 32'hFFFF_FFFF;
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial forever begin
        bit          known;
        logic [31:0] exp_rd;
        @(negedge clk);
        chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) chk("cmp_out_data", out_data, m_q[0]);
        exp_rd = model_rd(A, known);
        if (known) chk("cmp_rd", RD, exp_rd);
    end

    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd);
        WE = we; A = a; WD = wd;
        @(posedge clk); #1;
        WE = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        WE = 1'b0; A = a;
        #1;
        chk(name, RD, exp);
        @(posedge clk); #1;
    endtask

    logic [31:0] drain_vals [4] = '{32'h0B, 32'h0C, 32'h0D, 32'h99};

    initial begin
        reset = 1'b0; WE = 1'b0; A = STATUS; WD = 32'd0; out_ready = 1'b0;
        #2;
        chk("reset_status", RD, 32'h0000_0001);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // RAM store/load, same-cycle old value, alias and unmapped space
        cyc(1'b1, 32'h44, 32'h0);
        cyc(1'b1, 32'h40, 32'h1111_1111);
        WE = 1'b1; A = 32'h40; WD = 32'hDEAD_BEEF;
        #1;
        chk("ram_store_cycle_old", RD, 32'h1111_1111);
        @(posedge clk); #1; WE = 1'b0;
        rd_chk("ram_load_40", 32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_load_44", 32'h44, 32'h0);
        rd_chk("ram_alias", 32'h1040, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h0001_0040, 32'h1234_5678);
        rd_chk("unmapped_read", 32'h0001_0040, 32'h0);
        rd_chk("ram_after_unmapped", 32'h40, 32'hDEAD_BEEF);

        // Queue fill and overflow
        WE = 1'b1; A = OUTQ; WD = 32'd1;
        #1;
        chk("outq_reads_zero", RD, 32'd0);
        @(posedge clk); #1; WE = 1'b0;
        chk("valid_after_push", {31'd0, out_valid}, 32'd1);
        chk("head_after_push", out_data, 32'd1);
        for (int i = 2; i <= 4; i++) cyc(1'b1, OUTQ, 32'(i));
        A = STATUS; #1;
        chk("status_full", RD, 32'h42);
        cyc(1'b1, OUTQ, 32'd5);
        A = STATUS; #1;
        chk("status_ovf", RD, 32'h4A);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", out_data, 32'(i));
            @(posedge clk); #1;
        end
        chk("valid_after_drain", {31'd0, out_valid}, 32'd0);
        chk("status_drained", RD, 32'h09);
        out_ready = 1'b0;
        cyc(1'b1, STATUS, 32'h8);
        #1;
        chk("status_ovf_clear", RD, 32'h01);

        // Simultaneous push and pop while full
        for (int i = 10; i <= 13; i++) cyc(1'b1, OUTQ, 32'(i));
        out_ready = 1'b1;
        cyc(1'b1, OUTQ, 32'h99);
        out_ready = 1'b0;
        A = STATUS; #1;
        chk("full_push_pop_status", RD, 32'h42);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_push_pop_order", out_data, drain_vals[i]);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("status_after_drain2", RD, 32'h01);

`ifdef DBUS_TIMER_EN
        // Timer match and wrap
        cyc(1'b1, TIMER, 32'd1000);
        cyc(1'b1, TCMP, 32'd20);
        cyc(1'b1, STATUS, 32'h4);
        cyc(1'b1, TIMER, 32'd10);
        chk("timer_loaded", RD, 32'd10);
        A = STATUS; #1;
        chk("tmatch_k0", {31'd0, RD[2]}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            chk("tmatch_timing", {31'd0, RD[2]}, {31'd0, (k == 11)});
        end
        rd_chk("tcmp_read", TCMP, 32'd20);
        cyc(1'b1, TIMER, 32'hFFFF_FFFE);
        chk("timer_fffffffe", RD, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk("timer_ffffffff", RD, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("timer_wrap", RD, 32'h0);
`else
        // Timer compiled out
        cyc(1'b1, TIMER, 32'h1234);
        rd_chk("timer_off_read", TIMER, 32'h0);
        cyc(1'b1, TCMP, 32'h0);
        rd_chk("tcmp_off_read", TCMP, 32'h0);
        for (int k = 0; k < 4; k++) @(posedge clk);
        #1;
        rd_chk("status_bit2_off", STATUS, 32'h01);
`endif

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) cyc(1'b1, OUTQ, 32'h31 + 32'(i));
        A = STATUS; #1;
        chk("status_three", RD, 32'h30);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_status", RD, 32'h01);
        chk("async_reset_data", out_data, 32'd0);
        A = 32'h40; #1;
        chk("ram_survives_reset", RD, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        reset = 1'b1;

        // Mixed traffic, checked by the compare process
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 3) != 0;
            cyc((i % 4) != 3, OUTQ, 32'h100 + 32'(i));
        end
        out_ready = 1'b1;
        A = STATUS;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1;
        chk("final_status_empty", {28'd0, RD[3:0] & 4'b1011}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder for the single-cycle ARM core: decodes the core's data-memory port (address, write data, write enable, read data) into a word RAM plus a small block of memory-mapped I/O registers. Supplies read data combinationally in the same cycle, as the single-cycle datapath requires. Stores are taken on the rising clock edge. I/O consists of an output queue drained by a ready/valid consumer and an optional cycle timer with compare flag.

## Interface
- `ADDR_W`, 10: RAM index width; the RAM holds 2^ADDR_W 32-bit words.
- `FIFO_DEPTH`, 4: output queue depth; must be 2, 4 or 8.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `A`  in  32  byte address from the core's ALU result; `A[1:0]` is ignored.
- `WD`  in  32  store data.
- `WE`  in  1  store strobe, sampled at the clock edge.
- `RD`  out  32  load data, combinational from `A` and current state.
- `out_data`  out  32  head-of-queue word.
- `out_valid`  out  1  queue non-empty (registered).
- `out_ready`  in  1  consumer accepts the head word when `out_valid` is also high.

## Operation
- **RAM region** (`A[31:16]==0`):
  - The word index is `A[ADDR_W+1:2]`, and higher bits within the region alias.
  - Writes are synchronous. Reads are asynchronous.
  - RAM contents are not reset.
- **I/O region** (`A[31:4]==28'hFFFF_000`):
  - `0xFFFF0000` OUTQ:
    - A write pushes `WD` onto the queue.
    - A write while full is dropped and sets `ovf`.
    - A read returns 0.
  - `0xFFFF0004` STATUS, read layout: `{24'b0, count[3:0], ovf, tmatch, full, empty}`.
    - Writing STATUS with `WD[3]=1` clears `ovf`.
    - Writing STATUS with `WD[2]=1` clears `tmatch`.
    - All other STATUS bits ignore writes.
  - `0xFFFF0008` TIMER:
    - A read returns the counter.
    - A write loads `WD`.
  - `0xFFFF000C` TCMP: read/write compare value.
- **Unmapped addresses:** reads return 0 and writes are ignored.
- **Queue:**
  - Circular buffer with read/write pointers and a count.
  - A pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle:
    - Both take effect and count is unchanged.
    - This holds when full too: the pop frees the slot, so the push is accepted and `ovf` is not set.
  - `out_data` is the entry at the read pointer. It is don't-care while empty, but must not be X after reset; drive 0.
- **Timer:**
  - 32-bit free-running counter, increments every cycle and wraps `FFFFFFFF -> 0`.
  - A TIMER write loads `WD` instead of incrementing in that cycle.
  - When `counter == tcmp` at an edge, `tmatch` is set (sticky).
  - If a set and a software clear of `tmatch` occur in the same cycle, the set wins.
- **Reset values:**
  - Queue empty, pointers 0, `out_valid=0`, `out_data=0`.
  - `ovf=0`, `tmatch=0`.
  - Counter 0, `tcmp=FFFFFFFF`.
  - `RD` then reflects the reset state (e.g. STATUS reads `0x00000001`).

## Timing
- Load latency is 0 cycles: `RD` is a combinational function of `A` and the registered state.
- Store effects appear at the next rising edge.
  - A read of the same address in the store cycle returns the old value.
- Push into an empty queue: `out_valid` rises one cycle after the store edge. There is no bypass.
- The STATUS read in the push cycle reflects the pre-push state.
- Pop: the consumer samples `out_data` at the edge where `out_valid && out_ready`. The next entry, or `out_valid=0`, follows after that edge.
- `out_valid` does not depend combinationally on `out_ready`.
- Timer match: with `tcmp=N`, `tmatch` reads 1 starting in the cycle after the counter held `N`.
- Reset mid-operation:
  - Asserting `reset` low immediately clears all queue, flag and timer state, independent of `clk`.
  - Any queued data is discarded. RAM is untouched.

## Configuration
- `DBUS_TIMER_EN` defined:
  - Timer counter, TCMP and `tmatch` logic are built as described.
- `DBUS_TIMER_EN` undefined:
  - No counter or compare registers are built.
  - TIMER and TCMP read 0 and ignore writes.
  - STATUS bit 2 reads 0.
  - RAM and queue behaviour is unchanged.

## Test plan
- **RAM store/load:**
  - Stimulus: store `0xDEADBEEF` at `0x40`, then load `0x40` and `0x44`.
  - Required response: `RD=DEADBEEF` next cycle, then `RD=0` for `0x44` after an earlier store of 0 there.
  - Required response: the load of `0x40` in the store cycle itself returns the prior value.
- **Queue fill and overflow** (`FIFO_DEPTH=4`, `out_ready=0`):
  - Stimulus: push `1,2,3,4,5`.
  - Required response: STATUS = `0x42`, i.e. count 4, `ovf=0`, full, after the 4th push. STATUS = `0x4A` after the 5th.
  - Stimulus: raise `out_ready`.
  - Required response: pops `1,2,3,4` on consecutive edges, then `out_valid=0` and STATUS `0x09`.
  - Stimulus: write STATUS `0x8`.
  - Required response: STATUS = `0x01`.
- **Simultaneous push/pop at full:**
  - Stimulus: with the queue full and `out_ready=1`, push `0x99`.
  - Required response: count stays 4, `ovf` stays 0, and `0x99` emerges last.
- **Timer match** (`DBUS_TIMER_EN`):
  - Stimulus: write TCMP=20, then write TIMER=10.
  - Required response: `tmatch` reads 1 exactly 11 cycles after the TIMER store edge.
  - Stimulus: write TIMER=`FFFFFFFE`.
  - Required response: reads `FFFFFFFF`, then 0.
- **Timer compiled out:**
  - Stimulus: with `DBUS_TIMER_EN` undefined, write then read TIMER and TCMP.
  - Required response: reads return 0, and STATUS bit 2 never sets.
- **Asynchronous reset mid-stream:**
  - Stimulus: with 3 entries queued, assert `reset` low between edges.
  - Required response: `out_valid` drops immediately and STATUS reads `0x01`; RAM contents survive.
